// File: rtl/ram_pkg.sv
// Shared types and default widths for the burst RAM controller.
package ram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram_array.sv
// Single-port-per-direction storage: synchronous write, registered read.
// Latency: read data valid 1 cycle after re; rdata holds while re is low.
// Backpressure: none here; the controller gates re to stall the read stream.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents survive reset; only the read register is cleared.
    logic [DATA_W-1:0] Mem [2**ADDR_W];

    always @(posedge clk) begin
        if (we) begin
            Mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= Mem[raddr];
        end
    end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller over ram_array; BURST_WRAP_EN selects address wrap vs end-with-err at the top.
// Latency: first read beat 1 cycle after entering READ, then one beat per cycle; writes take one beat per cycle.
// Backpressure: rd_ready low freezes rd_data/rd_valid and the address; wr_valid low simply idles WRITE.
module ram_burst_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr
);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] cur_addr_nxt;
    logic              rd_valid_nxt;
    logic              err_nxt;
    logic              last_beat;
    logic              overrun;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;

`ifdef BURST_WRAP_EN
    assign last_beat = (cnt == '0);
    assign overrun   = 1'b0;
`else
    logic at_top;
    assign at_top    = (cur_addr == '1);
    // A burst ending exactly on the top word is legal; only one that would run past it flags err.
    assign last_beat = (cnt == '0) || at_top;
    assign overrun   = at_top && (cnt != '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_addr <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur_addr <= cur_addr_nxt;
            rd_valid <= rd_valid_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_addr_nxt = cur_addr;
        rd_valid_nxt = rd_valid;
        err_nxt      = err;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_raddr    = cur_addr;
        wr_ready     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state)
            IDLE: begin
                busy         = 1'b0;
                rd_valid_nxt = 1'b0;
                if (start) begin
                    cur_addr_nxt = base_addr;
                    cnt_nxt      = len;
                    err_nxt      = 1'b0;
                    state_nxt    = read_write ? READ : WRITE;
                end
            end
            WRITE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we       = 1'b1;
                    cur_addr_nxt = cur_addr + 1'b1;
                    cnt_nxt      = cnt - 1'b1;
                    if (last_beat) begin
                        state_nxt = DONE;
                        err_nxt   = overrun;
                    end
                end
            end
            READ: begin
                // rd_valid low only on the first READ cycle: prime the read register.
                if (!rd_valid) begin
                    mem_re       = 1'b1;
                    rd_valid_nxt = 1'b1;
                end else if (rd_ready) begin
                    cur_addr_nxt = cur_addr + 1'b1;
                    cnt_nxt      = cnt - 1'b1;
                    if (last_beat) begin
                        rd_valid_nxt = 1'b0;
                        state_nxt    = DONE;
                        err_nxt      = overrun;
                    end else begin
                        mem_re    = 1'b1;
                        mem_raddr = cur_addr + 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (cur_addr),
        .wdata (wr_data),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: preload read, backpressure, write/readback, top-of-array boundary, reset mid-burst.
module tb_ram_burst_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        read_write = 1'b0;
    logic [6:0]  base_addr = '0;
    logic [3:0]  len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  cur_addr;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] beats[$];
    logic [31:0] wq[$];
    int          n_done;
    int          first_cyc;
    int          last_cyc;
    int          hold_bad;
    int          overlap;
    logic        err_at_done;

    always #5 clk = ~clk;

    ram_burst_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .read_write (read_write),
        .base_addr  (base_addr),
        .len        (len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cur_addr   (cur_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic rw, input logic [6:0] b, input logic [3:0] l);
        @(posedge clk); #1;
        start      = 1'b1;
        read_write = rw;
        base_addr  = b;
        len        = l;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic run_read(input logic [6:0] b, input logic [3:0] l, input logic stall, input string tag);
        logic        stalled;
        logic [31:0] held;
        stalled = 1'b0;
        held    = '0;
        beats.delete();
        n_done = 0; hold_bad = 0; overlap = 0; first_cyc = -1; last_cyc = -1; err_at_done = 1'b0;
        issue(1'b1, b, l);
        chk({tag, "_cur_addr"}, {25'd0, cur_addr}, {25'd0, b});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int cyc = 0; cyc < 200; cyc++) begin
            rd_ready = stall ? cyc[0] : 1'b1;
            // A stray start mid-burst must be ignored.
            start      = stall && (cyc == 2);
            read_write = 1'b0;
            if (stalled && !(rd_valid && rd_data === held)) hold_bad++;
            if (rd_valid && wr_ready) overlap++;
            if (done) begin
                n_done++;
                err_at_done = err;
            end
            stalled = rd_valid && !rd_ready;
            held    = rd_data;
            if (rd_valid && rd_ready) begin
                beats.push_back(rd_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (!busy) break;
            @(posedge clk); #1;
        end
        rd_ready = 1'b0;
        start    = 1'b0;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_pulses"}, n_done, 32'd1);
        chk({tag, "_overlap"}, overlap, 32'd0);
    endtask

    task automatic run_write(input logic [6:0] b, input logic [3:0] l, input string tag);
        int idx;
        idx = 0; n_done = 0; err_at_done = 1'b0;
        issue(1'b0, b, l);
        for (int cyc = 0; cyc < 200; cyc++) begin
            wr_valid = (idx < wq.size());
            wr_data  = (idx < wq.size()) ? wq[idx] : 32'd0;
            if (done) begin
                n_done++;
                err_at_done = err;
            end
            if (wr_valid && wr_ready) idx++;
            if (!busy) break;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_pulses"}, n_done, 32'd1);
        chk({tag, "_beats"}, idx, wq.size());
    endtask

    initial begin
        int idx;
        for (int i = 0; i < 128; i++) dut.u_array.Mem[i] = i;

        #2 reset = 1'b1;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_cur_addr", {25'd0, cur_addr}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Preloaded read, full speed
        run_read(7'd0, 4'd9, 1'b0, "pre");
        chk("pre_count", beats.size(), 32'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("pre_beat%0d", i), (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF, i);
        chk("pre_span", last_cyc - first_cyc, 32'd9);

        // Backpressure on alternate cycles
        run_read(7'd4, 4'd3, 1'b1, "bp");
        chk("bp_count", beats.size(), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_beat%0d", i), (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF, 4 + i);
        chk("bp_hold", hold_bad, 32'd0);

        // Write then read back
        wq.delete();
        wq.push_back(32'hDEAD_BEEF);
        wq.push_back(32'h1234_5678);
        run_write(7'd20, 4'd1, "wr");
        chk("wr_mem20", dut.u_array.Mem[20], 32'hDEAD_BEEF);
        chk("wr_mem21", dut.u_array.Mem[21], 32'h1234_5678);
        chk("wr_mem22", dut.u_array.Mem[22], 32'd22);
        run_read(7'd20, 4'd1, 1'b0, "rb");
        chk("rb_count", beats.size(), 32'd2);
        chk("rb_beat0", (beats.size() > 0) ? beats[0] : 32'd0, 32'hDEAD_BEEF);
        chk("rb_beat1", (beats.size() > 1) ? beats[1] : 32'd0, 32'h1234_5678);

        // Top-of-array boundary
        run_read(7'd126, 4'd3, 1'b0, "top");
`ifdef BURST_WRAP_EN
        chk("top_count", beats.size(), 32'd4);
        chk("top_beat2", (beats.size() > 2) ? beats[2] : 32'hFFFF_FFFF, 32'd0);
        chk("top_beat3", (beats.size() > 3) ? beats[3] : 32'hFFFF_FFFF, 32'd1);
        chk("top_err_done", {31'd0, err_at_done}, 32'd0);
        chk("top_err_idle", {31'd0, err}, 32'd0);
`else
        chk("top_count", beats.size(), 32'd2);
        chk("top_err_done", {31'd0, err_at_done}, 32'd1);
        chk("top_err_idle", {31'd0, err}, 32'd1);
`endif
        chk("top_beat0", (beats.size() > 0) ? beats[0] : 32'd0, 32'd126);
        chk("top_beat1", (beats.size() > 1) ? beats[1] : 32'd0, 32'd127);

        // Single-beat burst; its start also clears a held err
        run_read(7'd3, 4'd0, 1'b0, "one");
        chk("one_count", beats.size(), 32'd1);
        chk("one_beat0", (beats.size() > 0) ? beats[0] : 32'd0, 32'd3);
        chk("one_err", {31'd0, err}, 32'd0);

        // Reset after the second beat of an 8-beat write
        issue(1'b0, 7'd40, 4'd7);
        idx = 0;
        n_done = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (idx == 2) begin
                wr_valid = 1'b0;
                reset    = 1'b1;
                break;
            end
            if (done) n_done++;
            wr_valid = 1'b1;
            wr_data  = 32'h1000 + idx;
            if (wr_ready) idx++;
            @(posedge clk); #1;
        end
        #1;
        chk("mid_reached", idx, 32'd2);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("mid_cur_addr", {25'd0, cur_addr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("mid_no_done", n_done, 32'd0);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        chk("mid_mem40", dut.u_array.Mem[40], 32'h1000);
        chk("mid_mem41", dut.u_array.Mem[41], 32'h1001);
        for (int i = 42; i < 48; i++) chk($sformatf("mid_mem%0d", i), dut.u_array.Mem[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 7, meaning address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter LEN_W, default 4, meaning burst-length field width; a burst is len+1 beats.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle burst request, sampled only in IDLE.
REQ-007 SHALL have port read_write, input, 1, meaning burst direction (1=read, 0=write), sampled with start.
REQ-008 SHALL have port base_addr, input, ADDR_W, meaning the first burst word address, sampled with start.
REQ-009 SHALL have port len, input, LEN_W, meaning beats minus one, sampled with start.
REQ-010 SHALL have ports wr_data (input, DATA_W), wr_valid (input, 1) and wr_ready (output, 1), meaning the write-beat handshake.
REQ-011 SHALL have ports rd_data (output, DATA_W), rd_valid (output, 1) and rd_ready (input, 1), meaning the read-beat handshake.
REQ-012 SHALL have outputs busy (1), done (1), err (1) and cur_addr (ADDR_W), meaning status.

Function
REQ-013 SHALL hold storage as a 2**ADDR_W x DATA_W array named Mem, directly accessible from a bench for preload and dump.
REQ-014 SHALL implement FSM states IDLE, WRITE, READ and DONE.
REQ-015 SHALL go IDLE->READ or IDLE->WRITE on start=1, latching base_addr into cur_addr and len into the beat counter.
REQ-016 SHALL, in WRITE, assert wr_ready, and on wr_valid&&wr_ready store wr_data at cur_addr, increment cur_addr and decrement the counter.
REQ-017 SHALL, in READ, present Mem[cur_addr] on rd_data with rd_valid=1 one cycle after the address is issued; read latency is 1 cycle.
REQ-018 SHALL hold rd_data and rd_valid stable while rd_valid=1 and rd_ready=0, with no beat lost or duplicated.
REQ-019 SHALL advance to the next read address only on a completed beat (rd_valid&&rd_ready), sustaining one beat per cycle when rd_ready stays 1.
REQ-020 SHALL enter DONE after the final beat, pulse done=1 for exactly one cycle, and then return to IDLE.
REQ-021 SHALL assert busy=1 in every state except IDLE and ignore start while busy.
REQ-022 SHALL treat len=0 as a single-beat burst.
REQ-023 SHALL, when a burst passes address 2**ADDR_W-1, behave as set out in the Configuration section.
REQ-024 SHALL never assert wr_ready and rd_valid in the same cycle.

Reset
REQ-025 SHALL, on reset assertion and regardless of clk, force IDLE; busy, done, err, wr_ready and rd_valid to 0; cur_addr and rd_data to 0.
REQ-026 SHALL abort a burst cut by reset mid-operation without a done pulse; words already written SHALL remain, and Mem SHALL NOT be cleared.

Configuration
REQ-027 SHALL, with BURST_WRAP_EN defined, wrap cur_addr from 2**ADDR_W-1 to 0 and continue the burst, with err held at 0.
REQ-028 SHALL, without BURST_WRAP_EN, end the burst after the beat at 2**ADDR_W-1, set err=1 together with the done pulse, and hold err until the next accepted start.

Structure
REQ-029 SHALL place the FSM state enum and the default-width constants in the shared package ram_pkg.
REQ-030 SHALL instantiate one sub-module, ram_array (parametrised sync-write, registered-read storage); the controller SHALL hold the FSM, counter and handshakes.

Verification
REQ-031 SHALL cover this preload case: Mem[0..9]=0..9; read burst base 0, len 9, rd_ready=1 -> rd_data 0..9 on 10 consecutive cycles, then one done pulse.
REQ-032 SHALL cover this backpressure case: read base 4, len 3, rd_ready low on alternate cycles -> beats 4,5,6,7 each delivered exactly once and held while stalled.
REQ-033 SHALL cover this write-then-read case: write base 20, len 1, data 0xDEADBEEF, 0x12345678 -> Mem[20..21] match, and a readback returns the same values.
REQ-034 SHALL cover the boundary with ADDR_W=7: read base 126, len 3 -> with BURST_WRAP_EN, Mem[126,127,0,1] and err=0; without it, 2 beats and err=1.
REQ-035 SHALL cover reset mid-burst: reset asserted after beat 2 of a write len 7 -> IDLE immediately, busy=0, no done pulse, Mem[base..base+1] written and the rest unchanged.
